// File: rtl/bmult_acc_pkg.sv
// Shared types and constants for the product accumulation stage.
//
// Contents:
//   state_e        : stage FSM states (idle, frame open, result presented)
//   PWDefault      : default product width (2x the 8-bit multiplier operand)
//   AccWDefault    : default accumulator width
//   CntWDefault    : default frame term-counter width
//   MaxAccW        : widest accumulator the add helper supports (ACC_W must be < MaxAccW)
//   add_carry()    : zero-extended add returning {carry-out, sum}
package bmult_acc_pkg;

  localparam int unsigned PWDefault   = 16;
  localparam int unsigned AccWDefault = 24;
  localparam int unsigned CntWDefault = 8;
  localparam int unsigned MaxAccW     = 64;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } state_e;

  // Operands are zero-extended by the caller, so for an ACC_W-bit add the carry-out lands in
  // bit ACC_W of the result and everything above it is zero.
  function automatic logic [MaxAccW:0] add_carry(input logic [MaxAccW-1:0] a,
                                                 input logic [MaxAccW-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/bmult_acc_add.sv
// Purely combinational ACC_W-bit adder with carry-out.
//
// Ports:
//   a_i     : addend (running accumulator, or zero when a frame is starting)
//   b_i     : addend (zero-extended product)
//   sum_o   : a_i + b_i modulo 2^ACC_W
//   carry_o : carry out of bit ACC_W-1
module bmult_acc_add
  import bmult_acc_pkg::*;
#(
  parameter int unsigned ACC_W = AccWDefault
) (
  input  logic [ACC_W-1:0] a_i,
  input  logic [ACC_W-1:0] b_i,
  output logic [ACC_W-1:0] sum_o,
  output logic             carry_o
);

  logic [MaxAccW-1:0] a_ext;
  logic [MaxAccW-1:0] b_ext;
  logic [MaxAccW:0]   full;
  logic               unused_hi;

  always_comb begin
    a_ext              = '0;
    b_ext              = '0;
    a_ext[ACC_W-1:0]   = a_i;
    b_ext[ACC_W-1:0]   = b_i;
    full               = add_carry(a_ext, b_ext);
    sum_o              = full[ACC_W-1:0];
    carry_o            = full[ACC_W];
  end

  // Bits above the carry are always zero for zero-extended operands.
  assign unused_hi = ^full[MaxAccW:ACC_W+1];

endmodule

// File: rtl/bmult_acc_stage.sv
// Accumulates a stream of unsigned multiplier products into per-frame sums.
// A frame ends on a beat with p_last set; the sum, term count and sticky overflow flag are then
// presented on the sum_* handshake and held until the sink takes them.
//
// Ports:
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   clr             : synchronous frame abort (ignored while a result is pending)
//   p_data/p_valid/p_last/p_ready : product input handshake
//   sum_data        : frame sum modulo 2^ACC_W
//   sum_count       : number of terms, saturating at 2^CNT_W-1
//   sum_ovf         : accumulator carry-out or counter saturation seen in the frame
//   sum_valid/sum_ready : result output handshake
module bmult_acc_stage
  import bmult_acc_pkg::*;
#(
  parameter int unsigned P_W   = PWDefault,
  parameter int unsigned ACC_W = AccWDefault,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [P_W-1:0]   p_data,
  input  logic             p_valid,
  input  logic             p_last,
  output logic             p_ready,
  output logic [ACC_W-1:0] sum_data,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_ovf,
  output logic             sum_valid,
  input  logic             sum_ready
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_data_q, sum_data_d;
  logic [CNT_W-1:0] sum_count_q, sum_count_d;
  logic             sum_ovf_q, sum_ovf_d;
  logic             sum_valid_q, sum_valid_d;

  logic             beat;
  logic [ACC_W-1:0] add_a, add_b, add_sum;
  logic             add_co;
  logic [CNT_W-1:0] cnt_next;
  logic             cnt_sat;
  logic             ovf_next;

  assign p_ready = (state_q != StHold);
  assign beat    = p_valid & p_ready;

  // Starting a frame from idle adds the product to zero, so one adder covers both the
  // first-beat load and the running accumulation.
  always_comb begin
    add_a            = (state_q == StAccum) ? acc_q : '0;
    add_b            = '0;
    add_b[P_W-1:0]   = p_data;
  end

  bmult_acc_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a_i     (add_a),
    .b_i     (add_b),
    .sum_o   (add_sum),
    .carry_o (add_co)
  );

  always_comb begin
    cnt_sat  = 1'b0;
    cnt_next = CNT_W'(1);
    ovf_next = 1'b0;
    if (state_q == StAccum) begin
      if (cnt_q == CntMax) begin
        cnt_next = cnt_q;
        cnt_sat  = 1'b1;
      end else begin
        cnt_next = cnt_q + CNT_W'(1);
      end
      ovf_next = ovf_q | add_co | cnt_sat;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    sum_data_d  = sum_data_q;
    sum_count_d = sum_count_q;
    sum_ovf_d   = sum_ovf_q;
    sum_valid_d = sum_valid_q;

    unique case (state_q)
      StIdle, StAccum: begin
        if (clr) begin
          // Abort wins over a coincident beat.
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = StIdle;
        end else if (beat) begin
          if (p_last) begin
            sum_data_d  = add_sum;
            sum_count_d = cnt_next;
            sum_ovf_d   = ovf_next;
            sum_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = StHold;
          end else begin
            acc_d   = add_sum;
            cnt_d   = cnt_next;
            ovf_d   = ovf_next;
            state_d = StAccum;
          end
        end
      end
      StHold: begin
        if (sum_ready) begin
          sum_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d     = StIdle;
        sum_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      sum_data_q  <= '0;
      sum_count_q <= '0;
      sum_ovf_q   <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      sum_data_q  <= sum_data_d;
      sum_count_q <= sum_count_d;
      sum_ovf_q   <= sum_ovf_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_data  = sum_data_q;
  assign sum_count = sum_count_q;
  assign sum_ovf   = sum_ovf_q;
  assign sum_valid = sum_valid_q;

endmodule

// File: tb/tb_bmult_acc_stage.sv
module tb_bmult_acc_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [15:0] p_data;
  logic        p_valid;
  logic        p_last;
  logic        sum_ready;

  logic        p_ready;
  logic [23:0] sum_data;
  logic [7:0]  sum_count;
  logic        sum_ovf;
  logic        sum_valid;

  logic        pr16;
  logic [15:0] sd16;
  logic [7:0]  sc16;
  logic        so16;
  logic        sv16;

  always #5 clk = ~clk;

  bmult_acc_stage #(.P_W(16), .ACC_W(24), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_last    (p_last),
    .p_ready   (p_ready),
    .sum_data  (sum_data),
    .sum_count (sum_count),
    .sum_ovf   (sum_ovf),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready)
  );

  bmult_acc_stage #(.P_W(16), .ACC_W(16), .CNT_W(8)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .p_data    (p_data),
    .p_valid   (p_valid),
    .p_last    (p_last),
    .p_ready   (pr16),
    .sum_data  (sd16),
    .sum_count (sc16),
    .sum_ovf   (so16),
    .sum_valid (sv16),
    .sum_ready (sum_ready)
  );

  typedef struct packed {
    logic [23:0] data;
    logic [7:0]  count;
    logic        ovf;
  } exp_t;

  exp_t q24[$];
  exp_t q16[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: true (unbounded) frame sum and term count.
  longint unsigned m_sum     = 0;
  int              m_terms   = 0;
  bit              m_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_result();
    exp_t e;
    logic [63:0] s;
    bit          sat;
    s       = m_sum;
    sat     = (m_terms > 255);
    e.count = sat ? 8'd255 : m_terms[7:0];
    e.data  = s[23:0];
    e.ovf   = (m_sum >= 64'h100_0000) || sat;
    q24.push_back(e);
    e.data  = {8'h00, s[15:0]};
    e.ovf   = (m_sum >= 64'h1_0000) || sat;
    q16.push_back(e);
  endtask

  // Drive one cycle (called just after a rising edge), check handshake status at the falling
  // edge, then advance the model at the next rising edge.
  task automatic cycle(input bit v, input logic [15:0] d, input bit l, input bit c, input bit r);
    p_valid   = v;
    p_data    = d;
    p_last    = l;
    clr       = c;
    sum_ready = r;
    @(negedge clk);
    chk("p_ready24", {63'b0, p_ready}, {63'b0, !m_pending});
    chk("p_ready16", {63'b0, pr16}, {63'b0, !m_pending});
    chk("sum_valid24", {63'b0, sum_valid}, {63'b0, m_pending});
    chk("sum_valid16", {63'b0, sv16}, {63'b0, m_pending});
    @(posedge clk);
    if (m_pending) begin
      if (r) m_pending = 1'b0;
    end else if (c) begin
      m_sum   = 0;
      m_terms = 0;
    end else if (v) begin
      m_sum   = m_sum + longint'(d);
      m_terms = m_terms + 1;
      if (l) begin
        push_result();
        m_pending = 1'b1;
        m_sum     = 0;
        m_terms   = 0;
      end
    end
    #1;
  endtask

  // Monitor: compare each delivered result and check that pending results stay stable.
  logic [23:0] prev_data  [2];
  logic [7:0]  prev_count [2];
  logic        prev_ovf   [2];
  bit          prev_hold  [2];

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        logic [23:0] md;
        logic [7:0]  mc;
        logic        mo;
        logic        mv;
        exp_t        e;
        if (d == 0) begin
          md = sum_data; mc = sum_count; mo = sum_ovf; mv = sum_valid;
        end else begin
          md = {8'h00, sd16}; mc = sc16; mo = so16; mv = sv16;
        end
        if (!mv) begin
          prev_hold[d] = 1'b0;
        end else begin
          if (prev_hold[d]) begin
            chk(d == 0 ? "hold_data24" : "hold_data16", {40'b0, md}, {40'b0, prev_data[d]});
            chk(d == 0 ? "hold_cnt24" : "hold_cnt16", {56'b0, mc}, {56'b0, prev_count[d]});
            chk(d == 0 ? "hold_ovf24" : "hold_ovf16", {63'b0, mo}, {63'b0, prev_ovf[d]});
          end
          if (sum_ready) begin
            if ((d == 0 ? q24.size() : q16.size()) == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL unexpected_result%0d: got data %0h, expected no result", d, md);
            end else begin
              if (d == 0) e = q24.pop_front();
              else        e = q16.pop_front();
              chk(d == 0 ? "sum_data24" : "sum_data16", {40'b0, md}, {40'b0, e.data});
              chk(d == 0 ? "sum_count24" : "sum_count16", {56'b0, mc}, {56'b0, e.count});
              chk(d == 0 ? "sum_ovf24" : "sum_ovf16", {63'b0, mo}, {63'b0, e.ovf});
            end
            prev_hold[d] = 1'b0;
          end else begin
            prev_hold[d]  = 1'b1;
            prev_data[d]  = md;
            prev_count[d] = mc;
            prev_ovf[d]   = mo;
          end
        end
      end
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_p_ready"}, {63'b0, p_ready}, 64'd1);
    chk({tag, "_sum_valid"}, {63'b0, sum_valid}, 64'd0);
    chk({tag, "_sum_data"}, {40'b0, sum_data}, 64'd0);
    chk({tag, "_sum_count"}, {56'b0, sum_count}, 64'd0);
    chk({tag, "_sum_ovf"}, {63'b0, sum_ovf}, 64'd0);
    chk({tag, "_sv16"}, {63'b0, sv16}, 64'd0);
    chk({tag, "_sd16"}, {48'b0, sd16}, 64'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) prev_hold[d] = 1'b0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    p_data    = '0;
    p_valid   = 1'b0;
    p_last    = 1'b0;
    sum_ready = 1'b0;
    #12;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Three-beat frame: 0xFE01 + 0x0001 + 0xFFFF.
    cycle(1, 16'hFE01, 0, 0, 1);
    cycle(1, 16'h0001, 0, 0, 1);
    cycle(1, 16'hFFFF, 1, 0, 1);
    cycle(0, 16'h0000, 0, 0, 1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Carry-out in the 16-bit instance.
    cycle(1, 16'hFFFF, 0, 0, 1);
    cycle(1, 16'h0002, 1, 0, 1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Single-beat frame, then result held against backpressure while products are offered.
    cycle(1, 16'h1234, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle(1, 16'hAAAA, 0, 1, 0);
    cycle(1, 16'hBBBB, 1, 0, 1);
    cycle(1, 16'h0007, 1, 0, 1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Abort mid-frame with a coincident beat.
    cycle(1, 16'h0100, 0, 0, 1);
    cycle(1, 16'h0055, 0, 1, 1);
    cycle(1, 16'h0005, 1, 0, 1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Long frame: both accumulator carry and counter saturation.
    for (int i = 0; i < 300; i++) cycle(1, 16'hFFFF, 0, 0, 1);
    cycle(1, 16'hFFFF, 1, 0, 1);
    cycle(0, 16'h0000, 0, 0, 1);

    // Asynchronous reset while a result is pending.
    cycle(1, 16'h4321, 1, 0, 0);
    cycle(0, 16'h0000, 0, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    m_sum     = 0;
    m_terms   = 0;
    m_pending = 1'b0;
    q24.delete();
    q16.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      bit          v, l, c, r;
      logic [15:0] d;
      v = ($urandom_range(0, 9) < 7);
      l = ($urandom_range(0, 99) < 15);
      c = ($urandom_range(0, 99) < 3);
      r = ($urandom_range(0, 1) == 1);
      d = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      cycle(v, d, l, c, r);
    end

    for (int i = 0; i < 3; i++) cycle(0, 16'h0000, 0, 0, 1);
    chk("queue24_drained", 64'(q24.size()), 64'd0);
    chk("queue16_drained", 64'(q16.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
